// File: rtl/output_scheduler.sv
// rtl/output_scheduler.sv - credit-based wormhole output scheduler with round-robin packet lock
module output_scheduler #(
    parameter int CREDIT_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_N,
    input  logic       req_E,
    input  logic       req_W,
    input  logic       req_S,
    input  logic       req_L,
    input  logic       tail_N,
    input  logic       tail_E,
    input  logic       tail_W,
    input  logic       tail_S,
    input  logic       tail_L,
    input  logic       credit_in,
    output logic       grant_N,
    output logic       grant_E,
    output logic       grant_W,
    output logic       grant_S,
    output logic       grant_L,
    output logic [1:0] credit_cnt,
    output logic       credit_err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [1:0] CMAX = 2'(CREDIT_MAX);

    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] pick;
    logic       found;
    logic [1:0] credit_q, credit_d;
    logic       err_q, err_d;
    logic [4:0] req_vec, tail_vec, grant_vec;
    logic       any_grant;

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        wrap5 = (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    assign req_vec  = {req_L, req_S, req_W, req_E, req_N};
    assign tail_vec = {tail_L, tail_S, tail_W, tail_E, tail_N};

    // First asserted requester, scanning cyclically from the priority pointer
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 0; i < 5; i++) begin
            if (!found && req_vec[wrap5({1'b0, ptr_q} + 4'(i))]) begin
                found = 1'b1;
                pick  = wrap5({1'b0, ptr_q} + 4'(i));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_vec = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    owner_d = pick;
                end
            end
            LOCKED: begin
                // Lock is held through stalls so the packet stays contiguous
                if (req_vec[owner_q] && credit_q != 2'd0) begin
                    grant_vec[owner_q] = 1'b1;
                    if (tail_vec[owner_q]) begin
                        state_d = IDLE;
                        ptr_d   = wrap5({1'b0, owner_q} + 4'd1);
                    end
                end
            end
        endcase
    end

    assign any_grant = |grant_vec;

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (any_grant && !credit_in) begin
            credit_d = credit_q - 2'd1;
        end else if (!any_grant && credit_in) begin
            if (credit_q >= CMAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 3'd0;
            ptr_q    <= 3'd0;
            credit_q <= CMAX;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign grant_N    = grant_vec[0];
    assign grant_E    = grant_vec[1];
    assign grant_W    = grant_vec[2];
    assign grant_S    = grant_vec[3];
    assign grant_L    = grant_vec[4];
    assign credit_cnt = credit_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_output_scheduler.sv
// tb/tb_output_scheduler.sv - table-driven checks of output_scheduler
module tb_output_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       credit_in = 1'b0;
    logic       grant_N, grant_E, grant_W, grant_S, grant_L;
    logic [1:0] credit_cnt;
    logic       credit_err;
    logic [4:0] gnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic [4:0] req;
        logic [4:0] tail;
        logic       cin;
        logic [4:0] exp_g;
        logic [1:0] exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    output_scheduler #(.CREDIT_MAX(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_N     (req[0]),
        .req_E     (req[1]),
        .req_W     (req[2]),
        .req_S     (req[3]),
        .req_L     (req[4]),
        .tail_N    (tail[0]),
        .tail_E    (tail[1]),
        .tail_W    (tail[2]),
        .tail_S    (tail[3]),
        .tail_L    (tail[4]),
        .credit_in (credit_in),
        .grant_N   (grant_N),
        .grant_E   (grant_E),
        .grant_W   (grant_W),
        .grant_S   (grant_S),
        .grant_L   (grant_L),
        .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    assign gnt = {grant_L, grant_S, grant_W, grant_E, grant_N};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic c,
                       input logic [4:0] g, input logic [1:0] cnt, input logic e);
        vec_t v;
        v.rst_n = r; v.req = rq; v.tail = tl; v.cin = c;
        v.exp_g = g; v.exp_cnt = cnt; v.exp_err = e;
        vecs.push_back(v);
    endtask

    initial begin
        // bit order {L,S,W,E,N}; expectations are outputs before the closing edge
        // single 3-flit packet from E
        add(1, 5'b00010, 5'b00000, 0, 5'b00000, 3, 0);
        add(1, 5'b00010, 5'b00000, 0, 5'b00010, 3, 0);
        add(1, 5'b00010, 5'b00000, 0, 5'b00010, 2, 0);
        add(1, 5'b00010, 5'b00010, 0, 5'b00010, 1, 0);
        // pointer now W: W beats N and S
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0);
        add(1, 5'b01101, 5'b00000, 0, 5'b00000, 1, 0);
        add(1, 5'b01101, 5'b00100, 0, 5'b00100, 1, 0);
        // refill, then overflow
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 2, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 3, 0);
        add(1, 5'b00000, 5'b00000, 0, 5'b00000, 3, 1);
        // N/S contention, pointer starts at S
        add(1, 5'b01001, 5'b01001, 0, 5'b00000, 3, 1);
        add(1, 5'b01001, 5'b01001, 1, 5'b01000, 3, 1);
        add(1, 5'b01001, 5'b01001, 0, 5'b00000, 3, 1);
        add(1, 5'b01001, 5'b01001, 1, 5'b00001, 3, 1);
        add(1, 5'b01001, 5'b01001, 0, 5'b00000, 3, 1);
        add(1, 5'b01001, 5'b01001, 1, 5'b01000, 3, 1);
        add(1, 5'b01001, 5'b01001, 0, 5'b00000, 3, 1);
        add(1, 5'b01001, 5'b01001, 1, 5'b00001, 3, 1);
        // reset clears sticky error
        add(0, 5'b00000, 5'b00000, 0, 5'b00000, 3, 0);
        // credit stall with N owner, E waiting
        add(1, 5'b00001, 5'b00000, 0, 5'b00000, 3, 0);
        add(1, 5'b00001, 5'b00000, 0, 5'b00001, 3, 0);
        add(1, 5'b00001, 5'b00000, 0, 5'b00001, 2, 0);
        add(1, 5'b00001, 5'b00000, 0, 5'b00001, 1, 0);
        add(1, 5'b00011, 5'b00000, 0, 5'b00000, 0, 0);
        add(1, 5'b00011, 5'b00000, 0, 5'b00000, 0, 0);
        add(1, 5'b00011, 5'b00000, 1, 5'b00000, 0, 0);
        add(1, 5'b00011, 5'b00001, 0, 5'b00001, 1, 0);
        // E locks with zero credit, then grant+credit in the same cycle
        add(1, 5'b00010, 5'b00000, 0, 5'b00000, 0, 0);
        add(1, 5'b00010, 5'b00010, 0, 5'b00000, 0, 0);
        add(1, 5'b00010, 5'b00010, 1, 5'b00000, 0, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0);
        add(1, 5'b00010, 5'b00000, 1, 5'b00010, 2, 0);
        add(1, 5'b00010, 5'b00010, 0, 5'b00010, 2, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 1, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 2, 0);
        add(1, 5'b00000, 5'b00000, 1, 5'b00000, 3, 0);
        add(1, 5'b00000, 5'b00000, 0, 5'b00000, 3, 1);
        add(1, 5'b00000, 5'b00000, 0, 5'b00000, 3, 1);
        // W mid-packet reset, then N wins from reset pointer
        add(1, 5'b00100, 5'b00000, 0, 5'b00000, 3, 1);
        add(1, 5'b00100, 5'b00000, 0, 5'b00100, 3, 1);
        add(0, 5'b00100, 5'b00000, 0, 5'b00000, 3, 0);
        add(1, 5'b00101, 5'b00000, 0, 5'b00000, 3, 0);
        add(1, 5'b00101, 5'b00000, 0, 5'b00001, 3, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_grant", int'(gnt), 0);
        chk("reset_cnt", int'(credit_cnt), 3);
        chk("reset_err", int'(credit_err), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst_n;
            req = vecs[i].req;
            tail = vecs[i].tail;
            credit_in = vecs[i].cin;
            @(negedge clk);
            chk($sformatf("row%0d_grant", i), int'(gnt), int'(vecs[i].exp_g));
            chk($sformatf("row%0d_cnt", i), int'(credit_cnt), int'(vecs[i].exp_cnt));
            chk($sformatf("row%0d_err", i), int'(credit_err), int'(vecs[i].exp_err));
        end

        // 3-flit packet from L after a fresh reset: one arbitration cycle, then 3 grants
        @(posedge clk); #1;
        reset = 1'b0; req = '0; tail = '0; credit_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            req  = (c < 4) ? 5'b10000 : 5'b00000;
            tail = (c == 3) ? 5'b10000 : 5'b00000;
            @(negedge clk);
            chk($sformatf("pktL_c%0d_grant", c), int'(gnt), (c >= 1 && c <= 3) ? 16 : 0);
        end
        chk("pktL_cnt_after", int'(credit_cnt), 0);

        // asynchronous reset drops an active grant without a clock edge
        @(posedge clk); #1;
        credit_in = 1'b1; req = 5'b00000; tail = '0;
        @(posedge clk); #1;
        credit_in = 1'b0; req = 5'b00001;
        @(posedge clk); #1;
        @(negedge clk);
        chk("async_pre_grant", int'(gnt), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_grant", int'(gnt), 0);
        chk("async_cnt", int'(credit_cnt), 3);
        chk("async_err", int'(credit_err), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_release_grant", int'(gnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_scheduler.md
OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 SHALL have parameter: CREDIT_MAX, default 3, downstream buffer slots (legal 1..3).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have ports: req_N, req_E, req_W, req_S, req_L  input  1 each  requester (LBDR) wants this output.
REQ-005 SHALL have ports: tail_N, tail_E, tail_W, tail_S, tail_L  input  1 each  requester's current flit is a tail flit.
REQ-006 SHALL have port: credit_in  input  1  one pulse per downstream slot freed.
REQ-007 SHALL have ports: grant_N, grant_E, grant_W, grant_S, grant_L  output  1 each  one-hot (or zero) flit-transfer grant.
REQ-008 SHALL have port: credit_cnt  output  2  current available downstream credits.
REQ-009 SHALL have port: credit_err  output  1  sticky credit-overflow flag.

Function
REQ-010 SHALL implement FSM with states IDLE and LOCKED; LOCKED stores a 3-bit owner (N,E,W,S,L).
REQ-011 SHALL keep a round-robin pointer (N,E,W,S,L order, wrap L->N) naming the highest-priority requester.
REQ-012 IDLE: if any req_*, SHALL select first asserted requester searching from pointer in cyclic order, enter LOCKED with that owner next cycle; no grant issued in IDLE.
REQ-013 IDLE with no req_* SHALL remain IDLE, pointer unchanged.
REQ-014 LOCKED: grant_<owner> SHALL be asserted combinationally iff req_<owner>=1 and credit_cnt/=0; all other grants 0.
REQ-015 LOCKED: grant_<owner>=1 with tail_<owner>=1 SHALL move to IDLE next cycle and set pointer to owner+1 (cyclic).
REQ-016 LOCKED: req_<owner>=0 or credit_cnt=0 SHALL hold LOCKED with same owner (packet stays atomic; other requesters blocked).
REQ-017 Head-to-tail packet of k flits with sufficient credit SHALL occupy k consecutive grant cycles after 1 arbitration cycle.
REQ-018 At most one grant SHALL be high in any cycle.
REQ-019 credit_cnt next = credit_cnt - g + c, g = OR of grants, c = credit_in; simultaneous g and c SHALL leave credit_cnt unchanged.
REQ-020 credit_in with credit_cnt=CREDIT_MAX and g=0 SHALL hold CREDIT_MAX and set credit_err=1 next cycle.
REQ-021 credit_err SHALL stay 1 until reset.
REQ-022 Underflow SHALL be impossible: no grant when credit_cnt=0 (REQ-014).
REQ-023 A credit_in arriving when credit_cnt=0 SHALL enable a grant in the following cycle, not the same cycle.

Reset
REQ-024 reset=0 SHALL immediately (asynchronously) force state IDLE, pointer N, credit_cnt=CREDIT_MAX, credit_err=0, all grants 0.
REQ-025 Reset mid-packet SHALL drop the lock; after release arbitration restarts from N with no residual owner.
REQ-026 Grants SHALL be 0 in the first cycle after reset release regardless of req_*.

Verification
REQ-027 Single packet: req_E=1, 3 flits, tail_E on 3rd, credit_cnt=3 -> cycle0 no grant, grant_E cycles1-3, credit_cnt 2,1,0, IDLE after, pointer=W.
REQ-028 Contention: req_N=req_S=1 continuous, 1-flit packets, credit_in each grant -> grants alternate N,S,N,S (round robin, no starvation).
REQ-029 Credit stall: owner N, credit_cnt=0, req_N=1 -> grant_N=0 until credit_in pulse; grant_N=1 exactly one cycle after pulse; req_E meanwhile never granted.
REQ-030 Simultaneous: grant and credit_in same cycle at credit_cnt=2 -> credit_cnt stays 2; credit_in at 3 with no grant -> stays 3, credit_err=1 and sticky.
REQ-031 Reset mid-packet: owner W after 1 of 3 flits, reset pulsed -> grants 0 at once, credit_cnt=3, credit_err=0; then req_W,req_N both high -> N locked first.
